// File: rtl/pc_call_stack_unit_pkg.sv
// Shared definitions for the program counter / call stack unit: command
// encoding in priority order and the stack-pointer width helper.
package pc_call_stack_unit_pkg;

  // Command codes, listed highest priority first. Reset sits above all of
  // these and is handled directly by the registers.
  localparam logic [2:0] CMD_LOAD   = 3'd0;
  localparam logic [2:0] CMD_CALL   = 3'd1;
  localparam logic [2:0] CMD_RET    = 3'd2;
  localparam logic [2:0] CMD_BRANCH = 3'd3;
  localparam logic [2:0] CMD_INC    = 3'd4;
  localparam logic [2:0] CMD_NONE   = 3'd7;

  // The stack pointer counts valid entries 0..depth, so it needs depth+1 codes.
  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // The storage array index only has to reach depth-1.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Picks one command from the raw strobes by fixed priority.
  function automatic logic [2:0] decode_cmd(input logic load,
                                            input logic call,
                                            input logic ret,
                                            input logic branch,
                                            input logic inc);
    logic [2:0] cmd;
    cmd = CMD_NONE;
    if (load)        cmd = CMD_LOAD;
    else if (call)   cmd = CMD_CALL;
    else if (ret)    cmd = CMD_RET;
    else if (branch) cmd = CMD_BRANCH;
    else if (inc)    cmd = CMD_INC;
    return cmd;
  endfunction

endpackage

// File: rtl/pc_call_stack_unit_ret_addr_stack.sv
// Return-address LIFO. Push is ignored when full, pop is ignored when empty;
// top is the most recently pushed entry and is only meaningful when not empty.
module ret_addr_stack
  import pc_call_stack_unit_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            push_data,
  output logic [WIDTH-1:0]            top,
  output logic [sp_width(DEPTH)-1:0]  sp,
  output logic                        full,
  output logic                        empty
);

  localparam int SPW = sp_width(DEPTH);
  localparam int AW  = idx_width(DEPTH);
  localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [SPW-1:0]   sp_q;
  logic [SPW-1:0]   sp_m1;
  logic             do_push;
  logic             do_pop;

  assign full    = (sp_q == SP_MAX);
  assign empty   = (sp_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !do_push;
  assign sp_m1   = sp_q - SPW'(1);
  assign sp      = sp_q;
  assign top     = mem[sp_m1[AW-1:0]];

  // Storage is deliberately left out of reset; only the pointer is cleared.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem[sp_q[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q <= '0;
    end else if (do_push) begin
      sp_q <= sp_q + SPW'(1);
    end else if (do_pop) begin
      sp_q <= sp_m1;
    end
  end

endmodule

// File: rtl/pc_call_stack_unit.sv
// Program counter with load, increment, relative branch and call/return
// through a hardware return-address stack, plus sticky stack error flags.
module pc_call_stack_unit
  import pc_call_stack_unit_pkg::*;
#(
  parameter int                WIDTH     = 12,
  parameter int                DEPTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0
) (
  input  logic                        clk,
  input  logic                        reset_pc,
  input  logic                        load_pc,
  input  logic                        increment_pc,
  input  logic                        branch_pc,
  input  logic                        call_pc,
  input  logic                        ret_pc,
  input  logic                        clr_err,
  input  logic [WIDTH-1:0]            DATA_pc,
  input  logic [WIDTH-1:0]            offset_pc,
  output logic [WIDTH-1:0]            op_of_pc,
  output logic [sp_width(DEPTH)-1:0]  sp,
  output logic                        stk_full,
  output logic                        stk_empty,
  output logic                        ovf_err,
  output logic                        unf_err
);

  // Command strobes are single-cycle and unacknowledged: a strobe high at a
  // rising edge is consumed at that edge, results appear one cycle later,
  // and there is no back-pressure (a refused call/return raises a flag).

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_plus1;
  logic [WIDTH-1:0] stk_top;
  logic [2:0]       cmd;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             ovf_q;
  logic             unf_q;
  logic             ovf_set;
  logic             unf_set;

  assign cmd      = decode_cmd(load_pc, call_pc, ret_pc, branch_pc, increment_pc);
  assign pc_plus1 = pc_q + WIDTH'(1);

  assign push    = (cmd == CMD_CALL) && !full;
  assign pop     = (cmd == CMD_RET) && !empty;
  assign ovf_set = (cmd == CMD_CALL) && full;
  assign unf_set = (cmd == CMD_RET) && empty;

  always_comb begin
    pc_d = pc_q;
    case (cmd)
      CMD_LOAD:   pc_d = DATA_pc;
      CMD_CALL:   pc_d = full ? pc_q : DATA_pc;
      CMD_RET:    pc_d = empty ? pc_q : stk_top;
      CMD_BRANCH: pc_d = pc_q + offset_pc;
      CMD_INC:    pc_d = pc_plus1;
      default:    pc_d = pc_q;
    endcase
  end

  ret_addr_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ret_addr_stack (
    .clk       (clk),
    .reset     (reset_pc),
    .push      (push),
    .pop       (pop),
    .push_data (pc_plus1),
    .top       (stk_top),
    .sp        (sp),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (reset_pc) begin
      pc_q <= RESET_VEC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // clr_err runs alongside any command; a fresh error in the same cycle wins.
  always_ff @(posedge clk) begin
    if (reset_pc) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q && !clr_err) || ovf_set;
      unf_q <= (unf_q && !clr_err) || unf_set;
    end
  end

  assign op_of_pc  = pc_q;
  assign stk_full  = full;
  assign stk_empty = empty;
  assign ovf_err   = ovf_q;
  assign unf_err   = unf_q;

endmodule
